// File: rtl/chip8_sprite_engine.sv
// CHIP-8 DXYN/00E0 coprocessor: fetches sprite rows over the shared memory read port,
// XORs them into the 64x32 framebuffer and reports collision; also blanks the screen.
module chip8_sprite_engine #(
    parameter int MEM_LATENCY = 1,
    parameter int WRAP        = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    input  logic [7:0]    x_in,
    input  logic [7:0]    y_in,
    input  logic [3:0]    n_in,
    input  logic [11:0]   i_in,
    input  logic [7:0]    mem_data_in,
    output logic          mem_read,
    output logic [11:0]   mem_addr_out,
    output logic          busy,
    output logic          done,
    output logic          collision,
    output logic [2047:0] display
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_WAIT, S_DRAW} state_t;

    state_t        state_r, state_s;
    logic [5:0]    x0_r, x0_s;
    logic [4:0]    y0_r, y0_s;
    logic [3:0]    n_r, n_s;
    logic [11:0]   i_r, i_s;
    logic [3:0]    row_r, row_s;
    logic [1:0]    wait_r, wait_s;
    logic          blank_r, blank_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          mem_read_r, mem_read_s;
    logic [11:0]   addr_r, addr_s;
    logic          coll_r, coll_s;
    logic [2047:0] display_r, display_s;
    logic [2047:0] draw_disp_s;
    logic          hit_s;
    logic [6:0]    px_s;
    logic [5:0]    py_s;

    assign mem_read     = mem_read_r;
    assign mem_addr_out = addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign collision    = coll_r;
    assign display      = display_r;

    // Framebuffer image after XORing the current sprite row in at (x0, y0+row).
    always_comb begin
        draw_disp_s = display_r;
        hit_s       = 1'b0;
        px_s        = 7'd0;
        py_s        = {1'b0, y0_r} + {2'b00, row_r};
        for (int j = 0; j < 8; j++) begin
            px_s = {1'b0, x0_r} + 7'(j);
            if (mem_data_in[3'(7 - j)] && ((WRAP != 0) || ((px_s < 7'd64) && (py_s < 6'd32)))) begin
                hit_s = hit_s | draw_disp_s[{py_s[4:0], px_s[5:0]}];
                draw_disp_s[{py_s[4:0], px_s[5:0]}] = ~draw_disp_s[{py_s[4:0], px_s[5:0]}];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Next-state and next-output logic for the request/fetch/draw sequence.
    always_comb begin
        state_s    = state_r;
        x0_s       = x0_r;
        y0_s       = y0_r;
        n_s        = n_r;
        i_s        = i_r;
        row_s      = row_r;
        wait_s     = wait_r;
        blank_s    = blank_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        mem_read_s = 1'b0;
        addr_s     = addr_r;
        coll_s     = coll_r;
        display_s  = display_r;
        case (state_r)
            S_IDLE: begin
                if (clear) begin
                    state_s = S_CLEAR;
                    blank_s = 1'b1;
                    busy_s  = 1'b1;
                end else if (start) begin
                    x0_s    = x_in[5:0];
                    y0_s    = y_in[4:0];
                    n_s     = n_in;
                    i_s     = i_in;
                    row_s   = 4'd0;
                    coll_s  = 1'b0;
                    busy_s  = 1'b1;
                    // An empty sprite finishes through CLEAR without touching the screen.
                    if (n_in == 4'd0) begin
                        state_s = S_CLEAR;
                        blank_s = 1'b0;
                    end else begin
                        state_s    = S_READ;
                        mem_read_s = 1'b1;
                        addr_s     = i_in;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (blank_r) begin
                    display_s = '0;
                end else begin
                    display_s = display_r;
                end
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            S_READ: begin
                if (MEM_LATENCY == 1) begin
                    state_s = S_DRAW;
                end else begin
                    state_s = S_WAIT;
                    wait_s  = 2'(MEM_LATENCY - 2);
                end
            end
            S_WAIT: begin
                if (wait_r == 2'd0) begin
                    state_s = S_DRAW;
                end else begin
                    wait_s = wait_r - 2'd1;
                end
            end
            S_DRAW: begin
                display_s = draw_disp_s;
                coll_s    = coll_r | hit_s;
                if (row_r == (n_r - 4'd1)) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    row_s      = row_r + 4'd1;
                    state_s    = S_READ;
                    mem_read_s = 1'b1;
                    addr_s     = i_r + {8'd0, row_r} + 12'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            x0_r       <= 6'd0;
            y0_r       <= 5'd0;
            n_r        <= 4'd0;
            i_r        <= 12'd0;
            row_r      <= 4'd0;
            wait_r     <= 2'd0;
            blank_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_read_r <= 1'b0;
            addr_r     <= 12'd0;
            coll_r     <= 1'b0;
            display_r  <= '0;
        end else begin
            state_r    <= state_s;
            x0_r       <= x0_s;
            y0_r       <= y0_s;
            n_r        <= n_s;
            i_r        <= i_s;
            row_r      <= row_s;
            wait_r     <= wait_s;
            blank_r    <= blank_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            mem_read_r <= mem_read_s;
            addr_r     <= addr_s;
            coll_r     <= coll_s;
            display_r  <= display_s;
        end
    end

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Bench for chip8_sprite_engine: two instances (latency 1 with wrap, latency 3 with clipping)
// checked every cycle against a transaction-level model, plus hand-computed directed cases.
module tb_chip8_sprite_engine;

    localparam int LATS [2] = '{1, 3};
    localparam int WRS  [2] = '{1, 0};

    logic          clk = 1'b0;
    logic          reset, start, clear;
    logic [7:0]    x_in, y_in;
    logic [3:0]    n_in;
    logic [11:0]   i_in;
    logic [7:0]    md    [2];
    logic          mrd   [2];
    logic [11:0]   maddr [2];
    logic          bsy   [2];
    logic          dn    [2];
    logic          col   [2];
    logic [2047:0] disp  [2];

    logic [7:0]    mem  [4096];
    logic [7:0]    pipe [2][4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int adq [$];

    bit            m_valid = 1'b0;
    bit            m_active [2];
    bit            m_draw   [2];
    int            m_acc [2], m_T [2], m_per [2], m_i [2];
    logic [2047:0] m_disp [2];
    logic          m_coll [2];

    chip8_sprite_engine #(.MEM_LATENCY(1), .WRAP(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .mem_data_in(md[0]), .mem_read(mrd[0]), .mem_addr_out(maddr[0]),
        .busy(bsy[0]), .done(dn[0]), .collision(col[0]), .display(disp[0])
    );

    chip8_sprite_engine #(.MEM_LATENCY(3), .WRAP(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .mem_data_in(md[1]), .mem_read(mrd[1]), .mem_addr_out(maddr[1]),
        .busy(bsy[1]), .done(dn[1]), .collision(col[1]), .display(disp[1])
    );

    always #5 clk = ~clk;

    // Synchronous memory with a per-instance read pipeline.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][0] <= mem[maddr[k]];
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end
    assign md[0] = pipe[0][LATS[0]-1];
    assign md[1] = pipe[1][LATS[1]-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_disp(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
        int nd, first;
        total++;
        if (act !== exp) begin
            nd = 0; first = -1;
            for (int b = 0; b < 2048; b++)
                if (act[b] !== exp[b]) begin nd++; if (first < 0) first = b; end
            bad++;
            $display("FAIL %s: got display differing in %0d pixels (first %0d: got %b expected %b) (cycle %0d)",
                     nm, nd, first, act[first], exp[first], cyc);
        end
    endtask

    // Reference draw: the sprite rows XORed pixel by pixel from plain coordinates.
    function automatic logic [2047:0] draw_f(input logic [2047:0] d, input int x0, input int y0,
                                             input int n, input int ib, input int wrap, output logic hit);
        logic [7:0] b;
        int px, py;
        hit = 1'b0;
        for (int r = 0; r < n; r++) begin
            b = mem[(ib + r) % 4096];
            for (int c = 0; c < 8; c++) begin
                px = x0 + c;
                py = y0 + r;
                if (wrap != 0) begin px = px % 64; py = py % 32; end
                if (b[7-c] && px < 64 && py < 32) begin
                    if (d[py*64+px]) hit = 1'b1;
                    d[py*64+px] = ~d[py*64+px];
                end
            end
        end
        return d;
    endfunction

    // Transaction model: decides acceptance and predicts the final screen and timing.
    always @(posedge clk) begin : model
        logic h;
        cyc = cyc + 1;
        if (!reset) begin
            m_valid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0; m_disp[k] = '0; m_coll[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_active[k] || (cyc - 1 - m_acc[k]) >= m_T[k]) begin
                    if (clear) begin
                        m_active[k] = 1'b1; m_acc[k] = cyc; m_T[k] = 1; m_draw[k] = 1'b0;
                        m_disp[k] = '0;
                    end else if (start) begin
                        m_active[k] = 1'b1; m_acc[k] = cyc; m_coll[k] = 1'b0;
                        if (n_in == 4'd0) begin
                            m_T[k] = 1; m_draw[k] = 1'b0;
                        end else begin
                            m_per[k]  = 1 + LATS[k];
                            m_T[k]    = int'(n_in) * m_per[k];
                            m_draw[k] = 1'b1;
                            m_i[k]    = int'(i_in);
                            m_disp[k] = draw_f(m_disp[k], int'(x_in) % 64, int'(y_in) % 32,
                                               int'(n_in), int'(i_in), WRS[k], h);
                            m_coll[k] = h;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin : compare
        int t;
        logic busy_e, done_e, rd_e;
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                t      = cyc - m_acc[k];
                busy_e = m_active[k] && (t < m_T[k]);
                done_e = m_active[k] && (t == m_T[k]);
                rd_e   = busy_e && m_draw[k] && ((t % m_per[k]) == 0);
                chk($sformatf("busy%0d", k), 64'(bsy[k]), 64'(busy_e));
                chk($sformatf("done%0d", k), 64'(dn[k]), 64'(done_e));
                chk($sformatf("mem_read%0d", k), 64'(mrd[k]), 64'(rd_e));
                if (rd_e)
                    chk($sformatf("mem_addr%0d", k), 64'(maddr[k]), 64'((m_i[k] + t / m_per[k]) % 4096));
                if (!busy_e) begin
                    chk_disp($sformatf("display%0d", k), disp[k], m_disp[k]);
                    chk($sformatf("collision%0d", k), 64'(col[k]), 64'(m_coll[k]));
                end
            end
        end
    end

    task automatic do_op(input logic clr, input logic st, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] i, input int pulse_at,
                         output int l0, output int l1, output int rdc);
        int e;
        @(posedge clk); #1;
        clear = clr; start = st; x_in = x; y_in = y; n_in = n; i_in = i;
        @(posedge clk); #1;
        e = cyc; clear = 1'b0; start = 1'b0;
        adq.delete(); l0 = -1; l1 = -1; rdc = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (mrd[0]) begin adq.push_back(int'(maddr[0])); rdc++; end
            if (mrd[1]) rdc++;
            if (dn[0] && l0 < 0) l0 = cyc - e;
            if (dn[1] && l1 < 0) l1 = cyc - e;
            if (cyc - e == pulse_at) begin
                start = 1'b1; n_in = 4'd1; x_in = 8'd9; i_in = 12'h100;
            end else begin
                start = 1'b0;
            end
            if (l0 >= 0 && l1 >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic chk_addrs(input string nm, input int base, input int cnt);
        int a;
        chk({nm, "_count"}, 64'(adq.size()), 64'(cnt));
        for (int j = 0; j < cnt; j++) begin
            a = (j < adq.size()) ? adq[j] : -1;
            chk($sformatf("%s[%0d]", nm, j), 64'(a), 64'((base + j) % 4096));
        end
    endtask

    initial begin : stim
        int l0, l1, rdc, e;
        logic [2047:0] font, ex;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        reset = 1'b0; start = 1'b0; clear = 1'b0;
        x_in = 8'd0; y_in = 8'd0; n_in = 4'd0; i_in = 12'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_mem_read", 64'(mrd[0]), 64'd0);
        chk("rst_mem_addr", 64'(maddr[0]), 64'd0);
        chk("rst_collision", 64'(col[0]), 64'd0);
        chk_disp("rst_display", disp[0], '0);
        reset = 1'b1;

        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0; mem[12'h100] = 8'hFF;
        font = '0;
        font[0] = 1'b1; font[1] = 1'b1; font[2] = 1'b1; font[3] = 1'b1;
        font[64] = 1'b1; font[67] = 1'b1; font[128] = 1'b1; font[131] = 1'b1;
        font[192] = 1'b1; font[195] = 1'b1;
        font[256] = 1'b1; font[257] = 1'b1; font[258] = 1'b1; font[259] = 1'b1;

        do_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, -1, l0, l1, rdc);
        chk("font_done_lat1", 64'(l0), 64'd10);
        chk("font_done_lat3", 64'(l1), 64'd20);
        chk_addrs("font_addr", 'h050, 5);
        chk_disp("font_disp0", disp[0], font);
        chk_disp("font_disp1", disp[1], font);
        chk("font_coll0", 64'(col[0]), 64'd0);

        do_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, -1, l0, l1, rdc);
        chk_disp("redraw_disp0", disp[0], '0);
        chk_disp("redraw_disp1", disp[1], '0);
        chk("redraw_coll0", 64'(col[0]), 64'd1);
        chk("redraw_coll1", 64'(col[1]), 64'd1);

        do_op(1'b0, 1'b1, 8'd62, 8'd31, 4'd1, 12'h100, -1, l0, l1, rdc);
        ex = '0; ex[2046] = 1'b1; ex[2047] = 1'b1;
        chk_disp("edge_clip_disp1", disp[1], ex);
        for (int b = 1984; b <= 1989; b++) ex[b] = 1'b1;
        chk_disp("edge_wrap_disp0", disp[0], ex);
        chk("edge_done_lat1", 64'(l0), 64'd2);

        do_op(1'b1, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, -1, l0, l1, rdc);
        chk("clear_done0", 64'(l0), 64'd1);
        chk("clear_done1", 64'(l1), 64'd1);
        chk("clear_reads", 64'(rdc), 64'd0);
        chk_disp("clear_disp0", disp[0], '0);
        chk("clear_coll0", 64'(col[0]), 64'd0);

        do_op(1'b0, 1'b1, 8'd70, 8'd33, 4'd1, 12'h100, -1, l0, l1, rdc);
        ex = '0; for (int b = 70; b <= 77; b++) ex[b] = 1'b1;
        chk_disp("origin_mod_disp0", disp[0], ex);
        chk_disp("origin_mod_disp1", disp[1], ex);

        do_op(1'b0, 1'b1, 8'd20, 8'd20, 4'd0, 12'h050, -1, l0, l1, rdc);
        chk("n0_done0", 64'(l0), 64'd1);
        chk("n0_done1", 64'(l1), 64'd1);
        chk("n0_reads", 64'(rdc), 64'd0);
        chk_disp("n0_disp0", disp[0], ex);

        do_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 3, l0, l1, rdc);
        chk("busy_start_done0", 64'(l0), 64'd10);
        chk("busy_start_done1", 64'(l1), 64'd20);
        chk_addrs("busy_start_addr", 'h050, 5);
        chk_disp("busy_start_disp0", disp[0], ex | font);

        @(posedge clk); #1;
        start = 1'b1; x_in = 8'd10; y_in = 8'd5; n_in = 4'd5; i_in = 12'h050;
        @(posedge clk); #1;
        e = cyc; start = 1'b0;
        while (cyc < e + 4) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_busy0", 64'(bsy[0]), 64'd0);
        chk("midreset_read0", 64'(mrd[0]), 64'd0);
        chk_disp("midreset_disp0", disp[0], '0);
        reset = 1'b1;

        mem[12'hFFE] = 8'h81; mem[12'hFFF] = 8'h42; mem[12'h000] = 8'h3C;
        do_op(1'b0, 1'b1, 8'd3, 8'd4, 4'd3, 12'hFFE, -1, l0, l1, rdc);
        chk("addrwrap_done0", 64'(l0), 64'd6);
        chk("addrwrap_done1", 64'(l1), 64'd12);
        chk_addrs("addrwrap_addr", 'hFFE, 3);
        ex = '0;
        ex[259] = 1'b1; ex[266] = 1'b1; ex[324] = 1'b1; ex[329] = 1'b1;
        ex[389] = 1'b1; ex[390] = 1'b1; ex[391] = 1'b1; ex[392] = 1'b1;
        chk_disp("addrwrap_disp1", disp[1], ex);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 24) == 0);
            x_in  = 8'($urandom);
            y_in  = 8'($urandom);
            n_in  = 4'($urandom);
            i_in  = 12'($urandom);
            reset = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0; reset = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bsy[0] && !bsy[1]) break;
        end
        chk("final_idle", 64'({bsy[0], bsy[1]}), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
